// File: rtl/sha2_stream_compress_if.sv
// Handshake/bus bundle for the SHA-2 streaming compression core.
// master = message source / digest sink, slave = the core.
interface sha2_stream_compress_if #(
  parameter int BLK_W = 8
) ();
  logic             start;
  logic             mode;
  logic [BLK_W-1:0] num_blocks;
  logic             abort;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [255:0]     digest;
  logic             digest_valid;
  logic             digest_ready;
  logic [BLK_W-1:0] blk_count;
  logic             busy;
  logic             err;

  modport master (
    output start, mode, num_blocks, abort, in_data, in_valid, digest_ready,
    input  in_ready, digest, digest_valid, blk_count, busy, err
  );

  modport slave (
    input  start, mode, num_blocks, abort, in_data, in_valid, digest_ready,
    output in_ready, digest, digest_valid, blk_count, busy, err
  );
endinterface

// File: rtl/sha2_stream_compress.sv
// SHA-256/SHA-224 streaming compression core: one round per cycle, words 0-15 taken
// straight from the input stream, words 16-63 expanded in a 16-entry rolling window.
module sha2_stream_compress #(
  parameter int BLK_W       = 8,
  parameter bit HOLD_DIGEST = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  sha2_stream_compress_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RLOAD, S_REXT, S_UPDATE, S_DONE
  } state_t;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t           state, state_nx;
  logic             mode_q;
  logic [BLK_W-1:0] nblk_q, blk_q;
  logic [5:0]       rnd_q;
  logic [31:0]      h_q [8];
  logic [31:0]      v_q [8];
  logic [31:0]      w_q [16];
  logic [255:0]     digest_q;
  logic             err_q;

  logic             in_ready;
  logic             do_round;
  logic             start_ok;
  logic             last_blk;
  logic [31:0]      w_t, t1, t2, ch, maj;
  logic [31:0]      h_sum [8];

  assign start_ok = bus.start && !bus.abort && (bus.num_blocks != '0);
  assign last_blk = (blk_q + BLK_W'(1)) == nblk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    do_round = 1'b0;
    case (state)
      S_IDLE:   if (start_ok) state_nx = S_INIT;
      S_INIT:   state_nx = S_RLOAD;
      S_RLOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          do_round = 1'b1;
          if (rnd_q == 6'd15) state_nx = S_REXT;
        end
      end
      S_REXT: begin
        do_round = 1'b1;
        if (rnd_q == 6'd63) state_nx = S_UPDATE;
      end
      S_UPDATE: state_nx = last_blk ? S_DONE : S_RLOAD;
      S_DONE:   if (!HOLD_DIGEST || bus.digest_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    // abort overrides everything, including the word handshake of this cycle
    if (bus.abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      in_ready = 1'b0;
      do_round = 1'b0;
    end
  end

  always_comb begin
    if (state == S_RLOAD) w_t = bus.in_data;
    else                  w_t = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    t1  = v_q[7] + bsig1(v_q[4]) + ch + K[rnd_q] + w_t;
    t2  = bsig0(v_q[0]) + maj;
    for (int unsigned i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      nblk_q   <= '0;
      blk_q    <= '0;
      rnd_q    <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        h_q[i] <= IV256[i];
        v_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      err_q <= (state == S_IDLE) && bus.start && !bus.abort && (bus.num_blocks == '0);
      if (bus.abort && state != S_IDLE) begin
        blk_q <= '0;
      end else begin
        case (state)
          S_IDLE: if (start_ok) begin
            mode_q <= bus.mode;
            nblk_q <= bus.num_blocks;
            blk_q  <= '0;
          end
          S_INIT: begin
            rnd_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
              h_q[i] <= mode_q ? IV224[i] : IV256[i];
              v_q[i] <= mode_q ? IV224[i] : IV256[i];
            end
          end
          S_RLOAD, S_REXT: if (do_round) begin
            rnd_q <= rnd_q + 6'd1;
            for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_t;
            v_q[7] <= v_q[6];
            v_q[6] <= v_q[5];
            v_q[5] <= v_q[4];
            v_q[4] <= v_q[3] + t1;
            v_q[3] <= v_q[2];
            v_q[2] <= v_q[1];
            v_q[1] <= v_q[0];
            v_q[0] <= t1 + t2;
          end
          S_UPDATE: begin
            blk_q <= blk_q + BLK_W'(1);
            rnd_q <= '0;
            for (int unsigned i = 0; i < 8; i++) h_q[i] <= h_sum[i];
            if (last_blk) begin
              if (mode_q)
                digest_q <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                             h_sum[4], h_sum[5], h_sum[6], 32'h0};
              else
                digest_q <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                             h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
            end else begin
              for (int unsigned i = 0; i < 8; i++) v_q[i] <= h_sum[i];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = (state == S_DONE);
  assign bus.blk_count    = blk_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.err          = err_q;

endmodule
